sfx_sequencer: RTL and testbench
================================

SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: ROM address width.
REQ-002 SHALL have parameter LEN_WHO, default 32000: whoosh length in samples.
REQ-003 SHALL have parameter LEN_SW, default 24000: sword length in samples.
REQ-004 SHALL have parameter LEN_CITY, default 32768: city loop length in samples.
REQ-005 SHALL have parameter ROM_LAT, default 2: cycles from rom_addr valid to rom_q valid (1..4).
REQ-006 SHALL have parameter ATTEN, default 0: arithmetic right-shift applied to samples (0..7).
REQ-007 SHALL have port clk, input, 1: audio clock, single clock domain.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port control, input, 2: effect select. 00 = stop, 01 = whoosh, 10 = sword, 11 = city loop.
REQ-010 SHALL have port sample_req, input, 1: one-cycle pulse from the codec requesting the next sample.
REQ-011 SHALL have port rom_q, input, 16: signed sample from the selected ROM.
REQ-012 SHALL have port rom_addr, output, ADDR_W: shared ROM address.
REQ-013 SHALL have port rom_sel, output, 2: ROM mux select, equal to the active effect code.
REQ-014 SHALL have port audio_output, output, 16: signed sample to the codec.
REQ-015 SHALL have port busy, output, 1: high when state is not IDLE.
REQ-016 SHALL have port overrun, output, 1: sticky flag; sample_req arrived during FETCH.

Function
REQ-017 SHALL implement an FSM with states IDLE, PLAY and FETCH.
REQ-018 SHALL register control into ctrl_q every cycle.
REQ-019 SHALL define trigger as (control != ctrl_q) and (control != 00).
REQ-020 On trigger, in any state, SHALL set rom_sel=control and rom_addr=0, enter PLAY next cycle, abort any in-flight fetch, and leave audio_output unchanged.
REQ-021 Holding control at the same nonzero value SHALL NOT retrigger; a different nonzero value SHALL preempt the current effect and restart it at address 0.
REQ-022 When control==00, in any state, SHALL enter IDLE next cycle with audio_output=0.
REQ-023 In PLAY, sample_req SHALL enter FETCH and load a latency counter with ROM_LAT.
REQ-024 In FETCH, SHALL decrement the counter each cycle; when it reaches 0, SHALL latch audio_output = rom_q >>> ATTEN (sign-preserving) and advance rom_addr.
REQ-025 Latency SHALL be exactly ROM_LAT+1 cycles from sample_req to audio_output update.
REQ-026 At the latch, if rom_addr == LEN-1 of the active effect: city SHALL wrap rom_addr to 0 and return to PLAY; whoosh/sword SHALL hold rom_addr and enter IDLE.
REQ-027 Otherwise, the latch SHALL increment rom_addr by 1 and return to PLAY.
REQ-028 In IDLE, sample_req SHALL set audio_output=0 on the next cycle, so a one-shot's last sample is played once, then silence.
REQ-029 sample_req in FETCH SHALL be ignored for fetching and SHALL set overrun=1 until reset.
REQ-030 If trigger and sample_req occur in the same cycle, the trigger SHALL win; no fetch starts and overrun is unaffected.
REQ-031 rom_addr SHALL never exceed LEN-1 of the active effect; LEN parameters SHALL be <= 2^ADDR_W.

Reset
REQ-032 While reset is high, asynchronously: state=IDLE, ctrl_q=00, rom_addr=0, rom_sel=00, audio_output=0, busy=0, overrun=0.
REQ-033 Reset asserted mid-FETCH SHALL discard the fetch; after release the block SHALL NOT resume until a new trigger.
REQ-034 If control is already nonzero when reset releases, it SHALL trigger on the first cycle after release (ctrl_q=00).

Verification
REQ-035 Reset, control 00->01, sample_req pulse, ROM_LAT=2, rom_q=16'h1234 -> busy=1 next cycle, audio_output=16'h1234 3 cycles after sample_req, rom_addr=1.
REQ-036 City with LEN_CITY=4, 5 sample_reqs spaced 10 cycles -> rom_addr sequence 1,2,3,0,1, busy stays 1.
REQ-037 Whoosh with LEN_WHO=3, 4 sample_reqs -> 3 samples output, busy=0 after third, fourth sample_req gives audio_output=0.
REQ-038 Sword at rom_addr=5, control->01 together with a sample_req -> rom_sel=01, rom_addr=0, no fetch, overrun=0.
REQ-039 Two sample_reqs 1 cycle apart -> one fetch, overrun=1, held until reset; ATTEN=2, rom_q=16'h8000 -> audio_output=16'hE000.
REQ-040 Reset pulse mid-FETCH -> all outputs 0 immediately, no audio_output update after release.

Source files
------------

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays one-shot or looping effects from a shared ROM,
// one sample per codec request, with a fixed ROM read latency.
module sfx_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int LEN_WHO  = 32000,
  parameter int LEN_SW   = 24000,
  parameter int LEN_CITY = 32768,
  parameter int ROM_LAT  = 2,
  parameter int ATTEN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        control,
  input  logic              sample_req,
  input  logic [15:0]       rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        rom_sel,
  output logic [15:0]       audio_output,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, PLAY, FETCH} state_t;

  localparam logic [ADDR_W-1:0] LAST_WHO  = ADDR_W'(LEN_WHO - 1);
  localparam logic [ADDR_W-1:0] LAST_SW   = ADDR_W'(LEN_SW - 1);
  localparam logic [ADDR_W-1:0] LAST_CITY = ADDR_W'(LEN_CITY - 1);

  state_t              state, state_d;
  logic [1:0]          ctrl_q;
  logic [2:0]          lat_cnt, lat_cnt_d;
  logic [ADDR_W-1:0]   addr_d, last_addr;
  logic [1:0]          sel_d;
  logic [15:0]         audio_d;
  logic                overrun_d;
  logic                trigger;
  logic signed [15:0]  sample_s;

  assign trigger  = (control != ctrl_q) && (control != 2'b00);
  assign sample_s = $signed(rom_q) >>> ATTEN;
  assign busy     = (state != IDLE);

  always_comb begin
    case (rom_sel)
      2'b01:   last_addr = LAST_WHO;
      2'b10:   last_addr = LAST_SW;
      default: last_addr = LAST_CITY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ctrl_q       <= 2'b00;
      lat_cnt      <= '0;
      rom_addr     <= '0;
      rom_sel      <= 2'b00;
      audio_output <= '0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_d;
      ctrl_q       <= control;
      lat_cnt      <= lat_cnt_d;
      rom_addr     <= addr_d;
      rom_sel      <= sel_d;
      audio_output <= audio_d;
      overrun      <= overrun_d;
    end
  end

  // Stop beats trigger, trigger beats everything else (including a same-cycle request).
  always_comb begin
    state_d   = state;
    lat_cnt_d = lat_cnt;
    addr_d    = rom_addr;
    sel_d     = rom_sel;
    audio_d   = audio_output;
    overrun_d = overrun;
    if (control == 2'b00) begin
      state_d = IDLE;
      audio_d = '0;
    end else if (trigger) begin
      state_d = PLAY;
      sel_d   = control;
      addr_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_req) audio_d = '0;
        end
        PLAY: begin
          if (sample_req) begin
            state_d   = FETCH;
            lat_cnt_d = 3'(ROM_LAT);
          end
        end
        FETCH: begin
          if (sample_req) overrun_d = 1'b1;
          if (lat_cnt == 3'd0) begin
            audio_d = sample_s;
            if (rom_addr == last_addr) begin
              if (rom_sel == 2'b11) begin
                addr_d  = '0;
                state_d = PLAY;
              end else begin
                state_d = IDLE;
              end
            end else begin
              addr_d  = rom_addr + ADDR_W'(1);
              state_d = PLAY;
            end
          end else begin
            lat_cnt_d = lat_cnt - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: a timestamp-based playback model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_sfx_sequencer;

  localparam int ADDR_W   = 8;
  localparam int LEN_WHO  = 3;
  localparam int LEN_SW   = 8;
  localparam int LEN_CITY = 4;
  localparam int ROM_LAT  = 2;
  localparam int ATTEN    = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        control = 2'b00;
  logic              sample_req = 1'b0;
  logic [15:0]       rom_q;
  logic [ADDR_W-1:0] rom_addr;
  logic [1:0]        rom_sel;
  logic [15:0]       audio_output;
  logic              busy;
  logic              overrun;

  sfx_sequencer #(
    .ADDR_W(ADDR_W), .LEN_WHO(LEN_WHO), .LEN_SW(LEN_SW), .LEN_CITY(LEN_CITY),
    .ROM_LAT(ROM_LAT), .ATTEN(ATTEN)
  ) dut (
    .clk(clk), .reset(reset), .control(control), .sample_req(sample_req),
    .rom_q(rom_q), .rom_addr(rom_addr), .rom_sel(rom_sel),
    .audio_output(audio_output), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [1:0] s, input logic [ADDR_W-1:0] a);
    if (s == 2'b11 && a == 8'd2) return 16'h8000;
    return 16'({s, a} * 32'd40503 + 32'd4660);
  endfunction

  // ROM with ROM_LAT register stages between address and data.
  logic [ADDR_W+1:0] pipe [ROM_LAT];
  always @(posedge clk) begin
    pipe[0] <= {rom_sel, rom_addr};
    for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rom_q = rom_word(pipe[ROM_LAT-1][ADDR_W+1:ADDR_W], pipe[ROM_LAT-1][ADDR_W-1:0]);

  typedef struct {
    logic [15:0]       audio;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        sel;
    logic              busy;
    logic              ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Playback model: tracks effect, position and the edge at which a requested sample lands.
  int                e_idx = 0;
  int                land  = -1;
  logic [1:0]        m_prev, m_sel;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_audio;
  logic              m_active, m_ovr;

  function automatic int len_of(input logic [1:0] s);
    if (s == 2'b01) return LEN_WHO;
    if (s == 2'b10) return LEN_SW;
    return LEN_CITY;
  endfunction

  function automatic logic [15:0] scaled(input logic [15:0] w);
    int v, d;
    v = int'($signed(w));
    d = 1 << ATTEN;
    if (v >= 0) v = v / d;
    else v = -((-v + d - 1) / d);
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_prev = 2'b00; m_sel = 2'b00; m_addr = '0; m_audio = '0;
    m_active = 1'b0; m_ovr = 1'b0; land = -1;
  endtask

  task automatic model_step(input logic [1:0] ctl, input logic req);
    e_idx++;
    if (ctl == 2'b00) begin
      m_active = 1'b0; m_audio = '0; land = -1;
    end else if (ctl != m_prev) begin
      m_sel = ctl; m_addr = '0; m_active = 1'b1; land = -1;
    end else if (!m_active) begin
      if (req) m_audio = '0;
    end else if (land < 0) begin
      if (req) land = e_idx + ROM_LAT + 1;
    end else begin
      if (req) m_ovr = 1'b1;
      if (e_idx == land) begin
        m_audio = scaled(rom_word(m_sel, m_addr));
        land = -1;
        if (int'(m_addr) == len_of(m_sel) - 1) begin
          if (m_sel == 2'b11) m_addr = '0;
          else m_active = 1'b0;
        end else begin
          m_addr = m_addr + 1'b1;
        end
      end
    end
    m_prev = ctl;
  endtask

  task automatic drive(input logic [1:0] ctl, input logic req, input logic rst);
    exp_t e;
    @(negedge clk);
    control = ctl; sample_req = req; reset = rst;
    if (rst) begin
      model_reset();
      #1;
      n_tests++;
      if (busy !== 1'b0 || rom_addr !== '0 || rom_sel !== 2'b00 ||
          audio_output !== 16'h0 || overrun !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset: got busy=%b addr=%0d sel=%0d audio=%h ovr=%b, want all zero",
                 busy, rom_addr, rom_sel, audio_output, overrun);
      end
    end else begin
      model_step(ctl, req);
    end
    e.audio = m_audio; e.addr = m_addr; e.sel = m_sel; e.busy = m_active; e.ovr = m_ovr;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (audio_output !== e.audio || rom_addr !== e.addr || rom_sel !== e.sel ||
            busy !== e.busy || overrun !== e.ovr) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t: got audio=%h addr=%0d sel=%0d busy=%b ovr=%b, want audio=%h addr=%0d sel=%0d busy=%b ovr=%b",
                   $time, audio_output, rom_addr, rom_sel, busy, overrun,
                   e.audio, e.addr, e.sel, e.busy, e.ovr);
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0] ctl;
    model_reset();
    drive(2'b00, 1'b0, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    // whoosh: four requests, the last one after the effect ends
    drive(2'b01, 1'b0, 1'b0);
    repeat (4) begin
      drive(2'b01, 1'b1, 1'b0);
      repeat (6) drive(2'b01, 1'b0, 1'b0);
    end
    // city loop wraps
    drive(2'b11, 1'b0, 1'b0);
    repeat (5) begin
      drive(2'b11, 1'b1, 1'b0);
      repeat (9) drive(2'b11, 1'b0, 1'b0);
    end
    // sword to address 5, then preempt with whoosh on a request cycle
    drive(2'b10, 1'b0, 1'b0);
    repeat (5) begin
      drive(2'b10, 1'b1, 1'b0);
      repeat (5) drive(2'b10, 1'b0, 1'b0);
    end
    drive(2'b01, 1'b1, 1'b0);
    repeat (3) drive(2'b01, 1'b0, 1'b0);
    // back-to-back requests raise overrun
    drive(2'b01, 1'b1, 1'b0);
    drive(2'b01, 1'b1, 1'b0);
    repeat (6) drive(2'b01, 1'b0, 1'b0);
    // reset during a fetch, release with control held nonzero
    drive(2'b01, 1'b1, 1'b0);
    drive(2'b01, 1'b0, 1'b0);
    drive(2'b01, 1'b0, 1'b1);
    repeat (6) drive(2'b01, 1'b0, 1'b0);
    drive(2'b00, 1'b1, 1'b0);
    repeat (4) drive(2'b00, 1'b0, 1'b0);

    ctl = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0)
        ctl = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      drive(ctl, ($urandom_range(0, 4) == 0), ($urandom_range(0, 499) == 0));
    end
    drive(ctl, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
